// File: rtl/text_renderer_if.sv
//------------------------------------------------------------------------------
// text_renderer_if
//
// Read bus between the text renderer and its two synchronous read-only
// memories: the character buffer and the 8x16 font ROM. Both memories return
// data one clock after the address is presented.
//
// Signals:
//   txt_addr   12  text-buffer read address (row*COLS+col)
//   txt_data    7  ASCII code returned by the text buffer
//   font_addr  11  {ascii, glyph_row} presented to the font ROM
//   font_data   8  glyph row from the font ROM, bit 7 = leftmost pixel
//
// Modports:
//   master  the renderer (drives addresses, receives data)
//   slave   the memory side (receives addresses, drives data)
//------------------------------------------------------------------------------
interface text_renderer_if;
    logic [11:0] txt_addr;
    logic [6:0]  txt_data;
    logic [10:0] font_addr;
    logic [7:0]  font_data;

    modport master (
        output txt_addr,
        output font_addr,
        input  txt_data,
        input  font_data
    );

    modport slave (
        input  txt_addr,
        input  font_addr,
        output txt_data,
        output font_data
    );
endinterface

// File: rtl/text_renderer.sv
//------------------------------------------------------------------------------
// text_renderer
//
// Converts VGA-timing pixel coordinates into character-cell fetches against a
// text buffer and an 8x16 font ROM, producing a monochrome pixel stream with a
// blinking cursor. Sync and blanking are delayed to match the memory read
// latency so the output stays aligned: everything sampled on one edge appears
// on the outputs three edges later. One pixel per clock, no stalls.
//
// Ports:
//   clk         pixel clock
//   rst_n       asynchronous active-low reset
//   pix_x       current pixel column (10 bits)
//   pix_y       current pixel row (10 bits)
//   active_in   visible-area flag
//   hsync_in    horizontal sync, active-low
//   vsync_in    vertical sync, active-low
//   mem         read bus to the text buffer and font ROM (master side)
//   cursor_en   cursor display enable
//   cursor_col  cursor cell column (7 bits)
//   cursor_row  cursor cell row (5 bits)
//   rgb         RGB444 pixel colour
//   pixel_on    glyph/cursor pixel lit
//   active_out  active_in delayed to match rgb
//   hsync_out   hsync_in delayed to match rgb
//   vsync_out   vsync_in delayed to match rgb
//------------------------------------------------------------------------------
module text_renderer #(
    parameter int          COLS      = 80,
    parameter int          ROWS      = 30,
    parameter logic [11:0] FG        = 12'hFFF,
    parameter logic [11:0] BG        = 12'h000,
    parameter int          BLINK_BIT = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [9:0]             pix_x,
    input  logic [9:0]             pix_y,
    input  logic                   active_in,
    input  logic                   hsync_in,
    input  logic                   vsync_in,
    text_renderer_if.master        mem,
    input  logic                   cursor_en,
    input  logic [6:0]             cursor_col,
    input  logic [4:0]             cursor_row,
    output logic [11:0]            rgb,
    output logic                   pixel_on,
    output logic                   active_out,
    output logic                   hsync_out,
    output logic                   vsync_out
);

    // Per-pixel information that travels alongside the memory reads.
    typedef struct packed {
        logic [2:0] bit_idx;
        logic       in_text;
        logic       active;
        logic       hsync;
        logic       vsync;
        logic       cursor;
    } sideband_t;

    // Syncs idle high so no false sync pulse leaves the pipeline while it
    // refills after reset.
    localparam sideband_t SB_RESET = '{
        bit_idx: 3'd0, in_text: 1'b0, active: 1'b0,
        hsync: 1'b1, vsync: 1'b1, cursor: 1'b0
    };

    // ------------------------------------------------------------------
    // Cell decode (combinational, from the live coordinates)
    // ------------------------------------------------------------------
    logic [6:0]  col;
    logic [5:0]  row;
    logic [11:0] col_w;
    logic [11:0] row_w;
    logic [11:0] cell_addr;
    logic        in_text;
    logic        cursor_hit;

    assign col        = pix_x[9:3];
    assign row        = pix_y[9:4];
    assign col_w      = {5'd0, col};
    assign row_w      = {6'd0, row};
    assign in_text    = active_in & (col_w < 12'(COLS)) & (row_w < 12'(ROWS));
    assign cell_addr  = row_w * 12'(COLS) + col_w;
    assign cursor_hit = cursor_en & (col == cursor_col) & (row == {1'b0, cursor_row});

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    sideband_t  sb_d1, sb_d2, sb_d3;
    logic [3:0] glyph_row_d1;
    logic [3:0] glyph_row_d2;

    // NOTE: all state uses non-blocking assignments so every stage samples
    // the previous stage's value from before the edge, never the new one.
    // NOTE: the reset is in the sensitivity list, so outputs go to their
    // reset values immediately, without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem.txt_addr <= '0;
            glyph_row_d1 <= '0;
            glyph_row_d2 <= '0;
            sb_d1        <= SB_RESET;
            sb_d2        <= SB_RESET;
            sb_d3        <= SB_RESET;
        end else begin
            // Stage 1: address the text buffer; off-grid cells read address 0
            // and their data is masked downstream.
            mem.txt_addr <= in_text ? cell_addr : 12'd0;
            glyph_row_d1 <= pix_y[3:0];
            sb_d1        <= '{
                bit_idx: pix_x[2:0], in_text: in_text, active: active_in,
                hsync: hsync_in, vsync: vsync_in, cursor: cursor_hit
            };
            // Stage 2: text data arrives; glyph row is re-registered so it
            // lines up with the character it belongs to.
            glyph_row_d2 <= glyph_row_d1;
            sb_d2        <= sb_d1;
            // Stage 3: font ROM is reading the glyph row.
            sb_d3        <= sb_d2;
        end
    end

    // The ROM address is formed from the freshly returned character code and
    // the glyph row of the same pixel.
    assign mem.font_addr = {mem.txt_data, glyph_row_d2};

    // ------------------------------------------------------------------
    // Frame counter for the cursor blink
    // ------------------------------------------------------------------
    logic [7:0] frame_cnt;
    logic       vsync_q;
    logic       armed;
    logic       blink;

    // 'armed' drops the first sample after reset: vsync_q starts high, so a
    // vsync_in already low at release would otherwise look like a new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            vsync_q   <= 1'b1;
            armed     <= 1'b0;
        end else begin
            vsync_q <= vsync_in;
            armed   <= 1'b1;
            if (armed && vsync_q && !vsync_in) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    assign blink = frame_cnt[BLINK_BIT];

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    logic        lit;
    logic        pixel_on_next;
    logic [11:0] rgb_next;

    always_comb begin
        // NOTE: every signal gets a default before any condition, so no
        // path can leave one unassigned and infer a latch.
        lit           = 1'b0;
        pixel_on_next = 1'b0;
        rgb_next      = 12'h000;
        lit           = sb_d3.in_text & mem.font_data[3'd7 - sb_d3.bit_idx];
        pixel_on_next = lit ^ (sb_d3.cursor & blink & sb_d3.in_text);
        if (sb_d3.active) begin
            rgb_next = pixel_on_next ? FG : BG;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb        <= 12'h000;
            pixel_on   <= 1'b0;
            active_out <= 1'b0;
            hsync_out  <= 1'b1;
            vsync_out  <= 1'b1;
        end else begin
            rgb        <= rgb_next;
            pixel_on   <= pixel_on_next;
            active_out <= sb_d3.active;
            hsync_out  <= sb_d3.hsync;
            vsync_out  <= sb_d3.vsync;
        end
    end

endmodule

// File: tb/tb_text_renderer.sv
//------------------------------------------------------------------------------
// tb_text_renderer
//
// Self-checking bench for text_renderer. Provides behavioural text-buffer and
// font-ROM memories, drives directed and random pixel streams, and compares
// every output cycle against a reference model that derives each pixel
// straight from the character grid and font contents.
//------------------------------------------------------------------------------
module tb_text_renderer;

    localparam int          COLS      = 80;
    localparam int          ROWS      = 30;
    localparam logic [11:0] FG        = 12'hFFF;
    localparam logic [11:0] BG        = 12'h000;
    localparam int          BLINK_BIT = 5;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic [9:0]  pix_x      = '0;
    logic [9:0]  pix_y      = '0;
    logic        active_in  = 1'b0;
    logic        hsync_in   = 1'b1;
    logic        vsync_in   = 1'b1;
    logic        cursor_en  = 1'b0;
    logic [6:0]  cursor_col = '0;
    logic [4:0]  cursor_row = '0;
    logic [11:0] rgb;
    logic        pixel_on;
    logic        active_out;
    logic        hsync_out;
    logic        vsync_out;

    text_renderer_if bus ();

    text_renderer #(
        .COLS(COLS), .ROWS(ROWS), .FG(FG), .BG(BG), .BLINK_BIT(BLINK_BIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .active_in  (active_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .mem        (bus),
        .cursor_en  (cursor_en),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .rgb        (rgb),
        .pixel_on   (pixel_on),
        .active_out (active_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Memories: single-cycle registered reads
    // ------------------------------------------------------------------
    logic [6:0] text_mem [0:4095];
    logic [7:0] font_mem [0:2047];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.txt_data  <= '0;
            bus.font_data <= '0;
        end else begin
            bus.txt_data  <= text_mem[bus.txt_addr];
            bus.font_data <= font_mem[bus.font_addr];
        end
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int vectors = 0;
    int errors  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic [11:0] taddr;
        logic [10:0] faddr;
        bit          lit;
        bit          in_text;
        bit          active;
        bit          cur;
        bit          hs;
        bit          vs;
    } exp_t;

    exp_t       exp_q[$];
    int         model_cnt;
    logic [7:0] cnt_at_edge;
    bit         prev_vs;
    bit         seen_sample;

    // Expected behaviour of the pixel currently presented on the inputs.
    function automatic exp_t predict();
        exp_t       e;
        int         col, row, gy, b, ascii;
        logic [7:0] glyph;
        col       = int'(pix_x) / 8;
        row       = int'(pix_y) / 16;
        gy        = int'(pix_y) % 16;
        b         = int'(pix_x) % 8;
        e.in_text = active_in && (col < COLS) && (row < ROWS);
        e.taddr   = e.in_text ? 12'(row * COLS + col) : 12'd0;
        ascii     = int'(text_mem[e.taddr]);
        glyph     = font_mem[ascii * 16 + gy];
        e.lit     = glyph[7 - b];
        e.faddr   = 11'(ascii * 16 + gy);
        e.cur     = cursor_en && (col == int'(cursor_col)) && (row == int'(cursor_row));
        e.active  = active_in;
        e.hs      = hsync_in;
        e.vs      = vsync_in;
        return e;
    endfunction

    // Frames are counted as high-to-low vsync transitions between consecutive
    // samples; the first sample after reset only establishes the level.
    // cnt_at_edge keeps the frame count in force just before the latest edge,
    // which is what the output stage uses for that edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            model_cnt   = 0;
            cnt_at_edge = '0;
            prev_vs     = 1'b1;
            seen_sample = 1'b0;
        end else begin
            cnt_at_edge = 8'(model_cnt);
            if (seen_sample && prev_vs && !vsync_in) model_cnt = (model_cnt + 1) % 256;
            prev_vs     = vsync_in;
            seen_sample = 1'b1;
            exp_q.push_back(predict());
        end
    end

    // Scoreboard: txt_addr reflects the latest sample, font_addr the one
    // before, and the colour outputs the sample taken three edges earlier.
    always @(negedge clk) begin : scoreboard
        exp_t        e;
        logic        blink;
        logic        pon;
        logic [11:0] rgb_e;
        if (rst_n && exp_q.size() > 0) begin
            check("txt_addr", 32'(bus.txt_addr), 32'(exp_q[$].taddr));
            if (exp_q.size() >= 2)
                check("font_addr", 32'(bus.font_addr), 32'(exp_q[$-1].faddr));
            if (exp_q.size() == 4) begin
                e     = exp_q.pop_front();
                blink = cnt_at_edge[BLINK_BIT];
                pon   = e.in_text & (e.lit ^ (e.cur & blink));
                rgb_e = e.active ? (pon ? FG : BG) : 12'h000;
                check("pixel_on",   32'(pixel_on),   32'(pon));
                check("rgb",        32'(rgb),        32'(rgb_e));
                check("active_out", 32'(active_out), 32'(e.active));
                check("hsync_out",  32'(hsync_out),  32'(e.hs));
                check("vsync_out",  32'(vsync_out),  32'(e.vs));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    // Present one pixel, to be sampled on the following edge.
    task automatic drive(input int x, input int y, input bit act, input bit hs, input bit vs);
        @(posedge clk);
        #1;
        pix_x     = 10'(x);
        pix_y     = 10'(y);
        active_in = act;
        hsync_in  = hs;
        vsync_in  = vs;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rgb"},      32'(rgb),          32'h0);
        check({tag, "_pixel_on"}, 32'(pixel_on),     32'h0);
        check({tag, "_active"},   32'(active_out),   32'h0);
        check({tag, "_hsync"},    32'(hsync_out),    32'h1);
        check({tag, "_vsync"},    32'(vsync_out),    32'h1);
        check({tag, "_txt_addr"}, 32'(bus.txt_addr), 32'h0);
    endtask

    logic [7:0] pat;

    initial begin
        for (int i = 0; i < 4096; i++) text_mem[i] = 7'($urandom_range(0, 127));
        for (int i = 0; i < 2048; i++) font_mem[i] = 8'($urandom);
        text_mem[82]         = 7'd65;
        font_mem[65 * 16 + 7] = 8'b0111_1110;
        pat                  = 8'b0111_1110;

        // Reset held while inputs toggle.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            pix_x     = 10'($urandom_range(0, 799));
            pix_y     = 10'($urandom_range(0, 524));
            active_in = 1'($urandom);
            hsync_in  = 1'($urandom);
            vsync_in  = 1'($urandom);
            @(negedge clk);
            check_reset_values("reset");
        end

        // Release straight into a sweep of glyph row 7 of 'A' at cell (2,1).
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        pix_y     = 10'd23;
        pix_x     = 10'd16;
        active_in = 1'b1;
        hsync_in  = 1'b1;
        vsync_in  = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            @(posedge clk);
            #1;
            if (i <= 8) check("dir_txt_addr", 32'(bus.txt_addr), 32'd82);
            if (i >= 2 && i <= 9) check("dir_font_addr", 32'(bus.font_addr), 32'(65 * 16 + 7));
            if (i == 3) check("dir_refill_active", 32'(active_out), 32'h0);
            if (i >= 4) begin
                check("dir_pixel_on", 32'(pixel_on), 32'(pat[7 - (i - 4)]));
                check("dir_rgb", 32'(rgb), 32'(pat[7 - (i - 4)] ? FG : BG));
            end
            if (i < 8) pix_x = 10'(16 + i);
            else       active_in = 1'b0;
        end

        // Column 80 and beyond: out of text even though active.
        pix_x     = 10'd640;
        active_in = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (i <= 4) check("oob_txt_addr", 32'(bus.txt_addr), 32'h0);
            if (i >= 4 && i <= 7) begin
                check("oob_pixel_on", 32'(pixel_on), 32'h0);
                check("oob_rgb", 32'(rgb), 32'(BG));
            end
            if (i < 4) pix_x = 10'(640 + i);
            else       active_in = 1'b0;
        end

        // Random pixels, blanking, syncs and cursors.
        for (int n = 0; n < 2000; n++) begin
            int x, y;
            if (n % 100 == 0) begin
                cursor_en  = 1'($urandom);
                cursor_col = 7'($urandom_range(0, 85));
                cursor_row = 5'($urandom_range(0, 31));
            end
            if ($urandom_range(0, 1) == 1) begin
                x = int'(cursor_col) * 8 + int'($urandom_range(0, 7));
                y = int'(cursor_row) * 16 + int'($urandom_range(0, 15));
            end else begin
                x = int'($urandom_range(0, 799));
                y = int'($urandom_range(0, 524));
            end
            drive(x, y, $urandom_range(0, 3) != 0, 1'($urandom),
                  ($urandom_range(0, 7) == 0) ? !vsync_in : vsync_in);
        end

        // Cursor blink over blank glyphs; reset released with vsync low.
        cursor_en = 1'b0;
        drive(0, 0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        repeat (3) drive(0, 0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;
        repeat (3) drive(0, 0, 1'b0, 1'b1, 1'b0);
        drive(0, 0, 1'b0, 1'b1, 1'b1);
        repeat (2) drive(0, 0, 1'b0, 1'b1, 1'b1);
        check("release_frame_cnt", 32'(dut.frame_cnt), 32'h0);

        text_mem[81] = 7'd0;
        text_mem[82] = 7'd0;
        text_mem[83] = 7'd0;
        for (int i = 0; i < 16; i++) font_mem[i] = 8'h00;
        cursor_en  = 1'b1;
        cursor_col = 7'd2;
        cursor_row = 5'd1;
        for (int f = 0; f < 64; f++) begin
            for (int x = 8; x < 32; x++) drive(x, 16 + (f % 16), 1'b1, 1'b1, 1'b1);
            repeat (4) drive(0, 0, 1'b0, 1'b1, 1'b1);
            repeat (2) drive(0, 0, 1'b0, 1'b1, 1'b0);
            repeat (2) drive(0, 0, 1'b0, 1'b1, 1'b1);
        end
        cursor_en = 1'b0;

        // Reset asserted mid-line at pix_x=300, released five cycles later.
        for (int x = 280; x < 300; x++) drive(x, 100, 1'b1, 1'b1, 1'b1);
        drive(300, 100, 1'b1, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_values("midline");
        check("midline_no_x", 32'($isunknown({rgb, pixel_on, active_out, hsync_out, vsync_out})), 32'h0);
        for (int x = 301; x < 305; x++) drive(x, 100, 1'b1, 1'b1, 1'b1);
        drive(305, 100, 1'b1, 1'b1, 1'b1);
        rst_n = 1'b1;
        for (int x = 306; x < 330; x++) drive(x, 100, 1'b1, 1'b1, 1'b1);
        repeat (5) drive(0, 0, 1'b0, 1'b1, 1'b1);
        check("midline_frame_cnt", 32'(dut.frame_cnt), 32'h0);
        check("midline_out_no_x", 32'($isunknown({rgb, pixel_on, active_out, hsync_out, vsync_out})), 32'h0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
